// File: rtl/ntt_bank_addr_gen.sv
// Radix-2 NTT address/bank generator: 4 butterflies (8 indices) per beat,
// split into bank (digit-sum mod 8) and in-bank address, with conflict flag.
// Ports: clk, rst_n (sync, active low), start, out_ready -> busy, out_valid,
//        stage, a0..a7 (banks), addr0..addr7 (idx>>3), conflict, last.
module ntt_bank_addr_gen #(
  parameter int LOGN      = 10,
  parameter int STAGE_GAP = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            out_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [LOGN-1:0] stage,
  output logic [2:0]      a0,
  output logic [2:0]      a1,
  output logic [2:0]      a2,
  output logic [2:0]      a3,
  output logic [2:0]      a4,
  output logic [2:0]      a5,
  output logic [2:0]      a6,
  output logic [2:0]      a7,
  output logic [LOGN-4:0] addr0,
  output logic [LOGN-4:0] addr1,
  output logic [LOGN-4:0] addr2,
  output logic [LOGN-4:0] addr3,
  output logic [LOGN-4:0] addr4,
  output logic [LOGN-4:0] addr5,
  output logic [LOGN-4:0] addr6,
  output logic [LOGN-4:0] addr7,
  output logic            conflict,
  output logic            last
);

  localparam int CW = LOGN - 3;
  localparam int BW = LOGN - 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int GL = (STAGE_GAP > 0) ? STAGE_GAP - 1 : 0;

  localparam logic [CW-1:0] C_LAST = {CW{1'b1}};
  localparam logic [4:0]    S_LAST = 5'(LOGN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GL);

  typedef logic [LOGN-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t state_q, state_d;
  logic [4:0]    s_q, s_d;
  logic [CW-1:0] c_q, c_d;
  logic [GW-1:0] g_q, g_d;

  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [2:0]      a_q[8], a_d[8];
  logic [CW-1:0]   addr_q[8], addr_d[8];
  logic            conflict_q, conflict_d;
  logic            last_q, last_d;
  logic            accept;
  idx_t            idx[8];

  // Butterfly b of stage s pairs indices top and top + 2^s, where top
  // inserts a zero at bit s of b.
  function automatic idx_t idx_f(input logic [4:0] s,
                                 input logic [BW-1:0] b,
                                 input logic bot);
    idx_t bx, mask, low, high, top;
    bx   = idx_t'(b);
    mask = (idx_t'(1) << s) - idx_t'(1);
    low  = bx & mask;
    high = bx >> s;
    top  = (high << (s + 5'd1)) | low;
    return bot ? (top | (idx_t'(1) << s)) : top;
  endfunction

  // Octal digit sum mod 8; 18 bits covers the largest legal LOGN.
  function automatic logic [2:0] bank_f(input idx_t v);
    logic [17:0] w;
    logic [2:0]  acc;
    w   = 18'(v);
    acc = 3'd0;
    for (int i = 0; i < 6; i++) begin
      acc = acc + w[3*i +: 3];
    end
    return acc;
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    g_d     = g_q;
    accept  = out_valid_q & out_ready;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          c_d     = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (c_q == C_LAST) begin
            c_d = '0;
            if (s_q == S_LAST) begin
              state_d = DONE;
              s_d     = '0;
            end else begin
              s_d = s_q + 5'd1;
              g_d = '0;
              if (STAGE_GAP > 0) state_d = GAP;
              else               state_d = RUN;
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      GAP: begin
        if (g_q == G_LAST) begin
          state_d = RUN;
          g_d     = '0;
        end else begin
          g_d = g_q + GW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next beat is derived from the next counters, so a stall recomputes
  // the same beat and the registered outputs hold.
  always_comb begin
    out_valid_d = (state_d == RUN);
    busy_d      = (state_d == RUN) || (state_d == GAP);
    stage_d     = out_valid_d ? LOGN'(s_d) : '0;
    last_d      = out_valid_d && (s_d == S_LAST) && (c_d == C_LAST);
    for (int k = 0; k < 4; k++) begin
      idx[2*k]   = idx_f(s_d, {c_d, 2'(k)}, 1'b0);
      idx[2*k+1] = idx_f(s_d, {c_d, 2'(k)}, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      a_d[i]    = out_valid_d ? bank_f(idx[i]) : 3'd0;
      addr_d[i] = out_valid_d ? idx[i][LOGN-1:3] : '0;
    end
    conflict_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (out_valid_d && (a_d[i] == a_d[j])) conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      g_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      stage_q     <= '0;
      conflict_q  <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        a_q[i]    <= 3'd0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      stage_q     <= stage_d;
      conflict_q  <= conflict_d;
      last_q      <= last_d;
      for (int i = 0; i < 8; i++) begin
        a_q[i]    <= a_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign stage     = stage_q;
  assign conflict  = conflict_q;
  assign last      = last_q;
  assign a0 = a_q[0];
  assign a1 = a_q[1];
  assign a2 = a_q[2];
  assign a3 = a_q[3];
  assign a4 = a_q[4];
  assign a5 = a_q[5];
  assign a6 = a_q[6];
  assign a7 = a_q[7];
  assign addr0 = addr_q[0];
  assign addr1 = addr_q[1];
  assign addr2 = addr_q[2];
  assign addr3 = addr_q[3];
  assign addr4 = addr_q[4];
  assign addr5 = addr_q[5];
  assign addr6 = addr_q[6];
  assign addr7 = addr_q[7];

endmodule

// File: tb/tb_ntt_bank_addr_gen.sv
// Testbench for ntt_bank_addr_gen (LOGN=10, STAGE_GAP=2).
// Directed table + full transform with random stalls + reset abort.
module tb_ntt_bank_addr_gen;

  localparam int LOGN = 10;
  localparam int NB   = 128;
  localparam int TOT  = 1280;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, out_valid, conflict, last;
  logic [9:0] stage;
  logic [2:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [6:0] addr0, addr1, addr2, addr3, addr4, addr5, addr6, addr7;

  ntt_bank_addr_gen #(.LOGN(10), .STAGE_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .stage(stage),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .addr4(addr4), .addr5(addr5), .addr6(addr6), .addr7(addr7),
    .conflict(conflict), .last(last)
  );

  always #5 clk = ~clk;

  logic [23:0] act_banks;
  logic [55:0] act_addr;
  logic [93:0] obs;
  assign act_banks = {a0, a1, a2, a3, a4, a5, a6, a7};
  assign act_addr  = {addr0, addr1, addr2, addr3,
                      addr4, addr5, addr6, addr7};
  assign obs = {out_valid, busy, stage, act_banks,
                act_addr, conflict, last};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          stg;
    int          beat;
    logic [23:0] banks;
    logic [55:0] addrs;
    logic        conf;
    logic        lst;
  } vec_t;

  vec_t tbl[7];

  int          exp_idx[TOT*8];
  logic [23:0] rec_banks[TOT];
  logic [55:0] rec_addr[TOT];
  logic [9:0]  rec_stage[TOT];
  logic        rec_conf[TOT];
  logic        rec_last[TOT];

  function automatic logic [2:0] bank_of(input int v);
    int sum;
    sum = 0;
    while (v > 0) begin
      sum += v % 8;
      v = v / 8;
    end
    return 3'(sum % 8);
  endfunction

  initial begin
    int p, acc, gapc, cyc, vi;
    logic stalled;
    logic [93:0] held;
    logic [23:0] eb;
    logic [55:0] ea;
    logic [2:0]  bk[8];
    logic        ec;

    tbl[0] = '{0, 0,
      {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
      {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b0, 1'b0};
    tbl[1] = '{0, 1,
      {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0},
      {7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1}, 1'b0, 1'b0};
    tbl[2] = '{1, 0,
      {3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7},
      {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b0, 1'b0};
    tbl[3] = '{2, 0,
      {3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7},
      {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b0, 1'b0};
    tbl[4] = '{3, 0,
      {3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4},
      {7'd0, 7'd1, 7'd0, 7'd1, 7'd0, 7'd1, 7'd0, 7'd1}, 1'b1, 1'b0};
    tbl[5] = '{9, 0,
      {3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4},
      {7'd0, 7'd64, 7'd0, 7'd64, 7'd0, 7'd64, 7'd0, 7'd64}, 1'b1, 1'b0};
    tbl[6] = '{9, 127,
      {3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6},
      {7'd63, 7'd127, 7'd63, 7'd127, 7'd63, 7'd127, 7'd63, 7'd127},
      1'b1, 1'b1};

    // Reference order: classic nested-loop butterfly enumeration.
    p = 0;
    for (int s = 0; s < LOGN; s++) begin
      int h;
      h = 1 << s;
      for (int j = 0; j < 1024; j += 2 * h) begin
        for (int i = 0; i < h; i++) begin
          exp_idx[p]     = j + i;
          exp_idx[p + 1] = j + i + h;
          p += 2;
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", obs, 94'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", obs, 94'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_busy", busy, 1'b1);
    chk("latency_stage", stage, 10'd0);

    acc = 0;
    gapc = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (acc < TOT && cyc < 20000) begin
      if (stalled) chk("stall_hold", obs, held);
      stalled = 1'b0;
      start = (cyc == 700);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid) begin
        if (out_ready) begin
          for (int l = 0; l < 8; l++) begin
            bk[l] = bank_of(exp_idx[8*acc + l]);
            eb[23-3*l -: 3] = bk[l];
            ea[55-7*l -: 7] = 7'(exp_idx[8*acc + l] >> 3);
          end
          ec = 1'b0;
          for (int l = 0; l < 8; l++)
            for (int m = l + 1; m < 8; m++)
              if (bk[l] == bk[m]) ec = 1'b1;
          chk("beat_banks", act_banks, eb);
          chk("beat_addr", act_addr, ea);
          chk("beat_stage", stage, 10'(acc / NB));
          chk("beat_conflict", conflict, ec);
          chk("beat_last", last, acc == TOT - 1);
          if (acc > 0)
            chk("gap_cycles", gapc, (acc % NB == 0) ? 2 : 0);
          rec_banks[acc] = act_banks;
          rec_addr[acc]  = act_addr;
          rec_stage[acc] = stage;
          rec_conf[acc]  = conflict;
          rec_last[acc]  = last;
          gapc = 0;
          acc++;
        end else begin
          stalled = 1'b1;
          held = obs;
        end
      end else begin
        gapc++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("beat_count", acc, TOT);
    chk("done_busy", busy, 1'b0);
    chk("done_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("idle_after", {busy, out_valid}, 2'b00);

    for (int t = 0; t < 7; t++) begin
      vi = tbl[t].stg * NB + tbl[t].beat;
      if (vi < acc) begin
        chk("tbl_banks", rec_banks[vi], tbl[t].banks);
        chk("tbl_addr", rec_addr[vi], tbl[t].addrs);
        chk("tbl_stage", rec_stage[vi], 10'(tbl[t].stg));
        chk("tbl_conflict", rec_conf[vi], tbl[t].conf);
        chk("tbl_last", rec_last[vi], tbl[t].lst);
      end else begin
        chk("tbl_missing", vi, acc);
      end
    end

    // Abort at beat 300 with a simultaneous start that must be ignored.
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 300 && cyc < 1000) begin
      if (out_valid) acc++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", acc, 300);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_outputs", obs, 94'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("abort_idle", obs, 94'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("replay_valid", out_valid, 1'b1);
    chk("replay_stage", stage, 10'd0);
    chk("replay_banks", act_banks, tbl[0].banks);
    chk("replay_addr", act_addr, tbl[0].addrs);
    chk("replay_conflict", conflict, tbl[0].conf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
